// File: rtl/pop_uart_tx.sv
// pop_uart_tx: captures one population path on start and streams it as 8N1 frames, LSB byte first.
// Optional UART_SYNC_HEADER_EN prepends a single 8'hA5 sync frame ahead of the payload.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | line high, waiting for start
// S_START | start bit (line low) for one bit time
// S_DATA  | eight data bits, LSB first
// S_STOP  | stop bit (line high); then next frame or finish
// S_DONE  | one-cycle done pulse, busy already low
module pop_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PATH_BITS    = 150
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [PATH_BITS-1:0] path,
    output logic                 busy,
    output logic                 done,
    output logic                 uart_out
);

    localparam int NBYTES   = (PATH_BITS + 7) / 8;
`ifdef UART_SYNC_HEADER_EN
    localparam int HDR_BITS = 8;
`else
    localparam int HDR_BITS = 0;
`endif
    localparam int NFRAMES  = NBYTES + HDR_BITS / 8;
    localparam int SHW      = NFRAMES * 8;
    localparam int TW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW       = (NFRAMES > 1) ? $clog2(NFRAMES) : 1;

    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(NFRAMES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]     r_state;
    logic [TW-1:0]  r_timer;
    logic [2:0]     r_bit_cnt;
    logic [BW-1:0]  r_byte_idx;
    logic [SHW-1:0] r_shift;
    logic           r_busy;
    logic           r_done;
    logic           r_uart;

    logic [SHW-1:0] w_load;
    logic           w_wrap;

    // Frame image: optional sync byte in the lowest slot, path above it, pad bits zero.
    always_comb begin
        w_load = '0;
        w_load[HDR_BITS +: PATH_BITS] = path;
`ifdef UART_SYNC_HEADER_EN
        w_load[7:0] = 8'hA5;
`endif
    end

    assign w_wrap = (r_timer == T_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_bit_cnt  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_uart     <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (start) begin
                        r_shift    <= w_load;
                        r_byte_idx <= '0;
                        r_bit_cnt  <= '0;
                        r_uart     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_wrap) begin
                        r_timer   <= '0;
                        r_bit_cnt <= '0;
                        r_uart    <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_wrap) begin
                        r_timer <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_bit_cnt == 3'd7) begin
                            r_uart  <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_uart    <= r_shift[1];
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_wrap) begin
                        r_timer <= '0;
                        if (r_byte_idx == B_LAST) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            // Back-to-back frames: next start bit follows the stop bit directly.
                            r_byte_idx <= r_byte_idx + 1'b1;
                            r_uart     <= 1'b0;
                            r_state    <= S_START;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DONE: begin
                    r_uart  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_uart  <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign uart_out = r_uart;

endmodule

// File: tb/tb_pop_uart_tx.sv
// Testbench for pop_uart_tx: scoreboard of expected frames/done cycles checked by a line decoder.
// Honours UART_SYNC_HEADER_EN to expect the leading 8'hA5 frame.
module tb_pop_uart_tx;

    localparam int CPB = 4;
`ifdef UART_SYNC_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int FRAME_CYC = 10 * CPB;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } frame_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start16 = 1'b0;
    logic         start150 = 1'b0;
    logic [15:0]  path16 = '0;
    logic [149:0] path150 = '0;
    logic         busy16, done16, uart16;
    logic         busy150, done150, uart150;
    logic         sel = 1'b0;

    frame_t q_frame[$];
    int     q_done[$];
    int     cyc = 0;
    int     n_tests = 0;
    int     n_fail = 0;

    int         rx_active = 0;
    int         rx_t = 0;
    int         rx_start = 0;
    logic [7:0] rx_byte = '0;

    pop_uart_tx #(.CLKS_PER_BIT(CPB), .PATH_BITS(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .path(path16),
        .busy(busy16), .done(done16), .uart_out(uart16)
    );

    pop_uart_tx #(.CLKS_PER_BIT(CPB), .PATH_BITS(150)) u_dut150 (
        .clk(clk), .rst_n(rst_n), .start(start150), .path(path150),
        .busy(busy150), .done(done150), .uart_out(uart150)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Decoder: first low sample is the start bit, bits sampled mid-bit afterwards.
    always @(negedge clk) begin
        logic w_line;
        logic w_done;
        frame_t f;
        w_line = sel ? uart150 : uart16;
        w_done = sel ? done150 : done16;
        if (!rst_n) begin
            rx_active = 0;
        end else begin
            if (w_done) begin
                if (q_done.size() == 0) chk("done_unexpected", cyc, -1);
                else chk("done_cyc", cyc, q_done.pop_front());
            end
            if (rx_active == 0) begin
                if (!w_line) begin
                    rx_active = 1;
                    rx_t = 0;
                    rx_start = cyc;
                    rx_byte = '0;
                end
            end else begin
                rx_t++;
                if (rx_t == CPB / 2) chk("start_bit", int'(w_line), 0);
                else if (rx_t > CPB / 2 && rx_t < CPB / 2 + 9 * CPB && (rx_t - CPB / 2) % CPB == 0)
                    rx_byte = {w_line, rx_byte[7:1]};
                else if (rx_t == CPB / 2 + 9 * CPB) begin
                    chk("stop_bit", int'(w_line), 1);
                    if (q_frame.size() == 0) chk("frame_unexpected", int'(rx_byte), -1);
                    else begin
                        f = q_frame.pop_front();
                        chk("frame_data", int'(rx_byte), int'(f.data));
                        chk("frame_start_cyc", rx_start, f.cyc);
                    end
                    rx_active = 0;
                end
            end
        end
    end

    task automatic expect_tx(input int base, input logic [159:0] data, input int nbytes);
        frame_t f;
        int k;
        k = 0;
        if (HDR != 0) begin
            f.data = 8'hA5;
            f.cyc  = base + 1;
            q_frame.push_back(f);
            k = 1;
        end
        for (int i = 0; i < nbytes; i++) begin
            f.data = data[8*i +: 8];
            f.cyc  = base + 1 + FRAME_CYC * (k + i);
            q_frame.push_back(f);
        end
        q_done.push_back(base + 1 + FRAME_CYC * (k + nbytes));
    endtask

    task automatic send16(input logic [15:0] p, input bit push, output int base);
        @(negedge clk);
        path16  = p;
        start16 = 1'b1;
        base    = cyc;
        if (push) expect_tx(base, 160'(p), 2);
        @(negedge clk);
        start16 = 1'b0;
    endtask

    task automatic at_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && (q_done.size() != 0 || q_frame.size() != 0); i++)
            @(negedge clk);
        chk("pending_frames", q_frame.size(), 0);
        chk("pending_done", q_done.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int base;
        int base2;
        int d_last;
        d_last = FRAME_CYC * (HDR + 2);

        // Reset state
        #12;
        chk("rst_uart", int'(uart16), 1);
        chk("rst_busy", int'(busy16), 0);
        chk("rst_done", int'(done16), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Scenario 1: basic two-byte transfer with latency checks
        chk("idle_busy", int'(busy16), 0);
        send16(16'h3C5A, 1'b1, base);
        chk("c1_busy", int'(busy16), 1);
        chk("c1_uart", int'(uart16), 0);
        at_cyc(base + d_last);
        chk("last_busy", int'(busy16), 1);
        chk("last_uart", int'(uart16), 1);
        at_cyc(base + d_last + 1);
        chk("done_busy", int'(busy16), 0);
        chk("done_level", int'(done16), 1);
        at_cyc(base + d_last + 2);
        chk("done_clear", int'(done16), 0);
        wait_idle(400);

        // Scenario 2: start while busy is ignored
        send16(16'h3C5A, 1'b1, base);
        at_cyc(base + 40);
        send16(16'hFFFF, 1'b0, base2);
        wait_idle(400);
        repeat (60) @(negedge clk);
        chk("s2_idle_uart", int'(uart16), 1);
        chk("s2_idle_busy", int'(busy16), 0);

        // Scenario 3: asynchronous reset mid-frame
        send16(16'h3C5A, 1'b1, base);
        at_cyc(base + 30);
        @(posedge clk);
        #2 rst_n = 1'b0;
        q_frame.delete();
        q_done.delete();
        #1;
        chk("async_rst_uart", int'(uart16), 1);
        chk("async_rst_busy", int'(busy16), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send16(16'h0001, 1'b1, base);
        wait_idle(400);

        // Scenario 4: start held through the done cycle; path changes after capture
        send16(16'h1234, 1'b1, base);
        path16 = 16'($urandom);
        at_cyc(base + d_last + 1);
        chk("s4_done", int'(done16), 1);
        start16 = 1'b1;
        path16  = 16'hBEEF;
        @(negedge clk);
        base2 = cyc;
        expect_tx(base2, 160'(16'hBEEF), 2);
        @(negedge clk);
        start16 = 1'b0;
        path16  = 16'h0000;
        wait_idle(400);

        // Scenario 6: 150-bit path, pad bits of last byte are zero
        sel = 1'b1;
        @(negedge clk);
        path150  = '1;
        start150 = 1'b1;
        base     = cyc;
        expect_tx(base, 160'(path150), 19);
        @(negedge clk);
        start150 = 1'b0;
        wait_idle(2000);

        @(negedge clk);
        path150  = {22'($urandom), $urandom, $urandom, $urandom, $urandom};
        start150 = 1'b1;
        base     = cyc;
        expect_tx(base, 160'(path150), 19);
        @(negedge clk);
        start150 = 1'b0;
        path150  = '0;
        wait_idle(2000);
        sel = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
